host_memory_arbiter: RTL and testbench

//  Two-master Avalon-MM arbiter for the 2048x32 single-port on-chip memory (HostSystem_memory).

---
 rtl/host_memory_arbiter.sv | 178 +++++++++++++++++
 tb/tb_host_memory_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/host_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : host_memory_arbiter
// Description : Two-master Avalon-MM arbiter in front of the single-port
//               2048x32 on-chip memory. Burst-limited round-robin grant,
//               waitrequest stall for the losing master, and a fixed
//               one-cycle readdatavalid return routed to the reading master.
// Ports       : clk, reset           - clock, synchronous active-high reset
//               m0_* / m1_*          - Avalon-MM slave ports (M0 = CPU data,
//                                      M1 = DMA/debug)
//               mem_*                - single Avalon-MM master port to RAM s1
// Revision    : 1.0 - initial release
// ============================================================================
module host_memory_arbiter #(
    parameter int AW        = 11,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    // master 0
    input  logic [AW-1:0]     m0_address,
    input  logic [DW/8-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DW-1:0]     m0_writedata,
    output logic              m0_waitrequest,
    output logic [DW-1:0]     m0_readdata,
    output logic              m0_readdatavalid,
    // master 1
    input  logic [AW-1:0]     m1_address,
    input  logic [DW/8-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DW-1:0]     m1_writedata,
    output logic              m1_waitrequest,
    output logic [DW-1:0]     m1_readdata,
    output logic              m1_readdatavalid,
    // memory side
    output logic [AW-1:0]     mem_address,
    output logic [DW/8-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DW-1:0]     mem_writedata,
    output logic              mem_clken,
    input  logic [DW-1:0]     mem_readdata
);

    localparam logic [3:0] c_max_burst = 4'(MAX_BURST);
    localparam logic [3:0] c_cnt_sat   = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN0 = 2'd1,
        S_OWN1 = 2'd2
    } state_t;

    state_t     r_state;
    logic [3:0] r_burst_cnt;
    logic       r_last;       // last master granted (round-robin pointer)
    logic       r_rd_pend;
    logic       r_rd_owner;

    logic       w_req0;
    logic       w_req1;
    logic       w_grant0;
    logic       w_grant1;
    logic       w_grant_any;
    logic       w_same_owner;
    logic       w_grant_read;

    assign w_req0 = m0_read | m0_write;
    assign w_req1 = m1_read | m1_write;

    // Grant is suppressed while reset is held so nothing reaches the RAM and
    // requesters simply see waitrequest.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (!reset) begin
            case (r_state)
                S_IDLE: begin
                    if (w_req0 && w_req1) begin
                        w_grant0 = r_last;
                        w_grant1 = ~r_last;
                    end else begin
                        w_grant0 = w_req0;
                        w_grant1 = w_req1;
                    end
                end
                S_OWN0: begin
                    if (w_req0 && ((r_burst_cnt < c_max_burst) || !w_req1))
                        w_grant0 = 1'b1;
                    else
                        w_grant1 = w_req1;
                end
                S_OWN1: begin
                    if (w_req1 && ((r_burst_cnt < c_max_burst) || !w_req0))
                        w_grant1 = 1'b1;
                    else
                        w_grant0 = w_req0;
                end
                default: begin
                    w_grant0 = 1'b0;
                    w_grant1 = 1'b0;
                end
            endcase
        end
    end

    assign w_grant_any  = w_grant0 | w_grant1;
    assign w_same_owner = (w_grant0 && (r_state == S_OWN0)) ||
                          (w_grant1 && (r_state == S_OWN1));
    // read+write together from one master counts as a write
    assign w_grant_read = (w_grant0 & m0_read & ~m0_write) |
                          (w_grant1 & m1_read & ~m1_write);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_burst_cnt <= 4'd0;
            r_last      <= 1'b1;
            r_rd_pend   <= 1'b0;
            r_rd_owner  <= 1'b0;
        end else begin
            r_rd_pend  <= w_grant_read;
            r_rd_owner <= w_grant1;
            if (w_grant0) begin
                r_state <= S_OWN0;
                r_last  <= 1'b0;
            end else if (w_grant1) begin
                r_state <= S_OWN1;
                r_last  <= 1'b1;
            end else begin
                r_state <= S_IDLE;
            end
            if (!w_grant_any)
                r_burst_cnt <= 4'd0;
            else if (!w_same_owner)
                r_burst_cnt <= 4'd1;
            else if (r_burst_cnt != c_cnt_sat)
                r_burst_cnt <= r_burst_cnt + 4'd1;
        end
    end

    assign m0_waitrequest = w_req0 & ~w_grant0;
    assign m1_waitrequest = w_req1 & ~w_grant1;

    // Memory-side mux: all zero when nobody owns the port this cycle.
    always_comb begin
        mem_address    = '0;
        mem_byteenable = '0;
        mem_writedata  = '0;
        mem_write      = 1'b0;
        if (w_grant0) begin
            mem_address    = m0_address;
            mem_byteenable = m0_byteenable;
            mem_writedata  = m0_writedata;
            mem_write      = m0_write;
        end else if (w_grant1) begin
            mem_address    = m1_address;
            mem_byteenable = m1_byteenable;
            mem_writedata  = m1_writedata;
            mem_write      = m1_write;
        end
    end

    assign mem_chipselect = w_grant_any;
    assign mem_clken      = 1'b1;

    // RAM data is broadcast; only the valid strobe is steered.
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;
    assign m0_readdatavalid = r_rd_pend & ~r_rd_owner & ~reset;
    assign m1_readdatavalid = r_rd_pend &  r_rd_owner & ~reset;

endmodule
`default_nettype wire

// File: tb/tb_host_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_host_memory_arbiter
// Description : Bench for host_memory_arbiter with a behavioural RAM, a
//               cycle-level arbitration/scoreboard model and directed checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_host_memory_arbiter;

    localparam int AW        = 11;
    localparam int DW        = 32;
    localparam int MAX_BURST = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [10:0]   m0_address = '0, m1_address = '0;
    logic [3:0]    m0_byteenable = '0, m1_byteenable = '0;
    logic          m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
    logic [31:0]   m0_writedata = '0, m1_writedata = '0;
    logic          m0_waitrequest, m1_waitrequest;
    logic [31:0]   m0_readdata, m1_readdata;
    logic          m0_readdatavalid, m1_readdatavalid;
    logic [10:0]   mem_address;
    logic [3:0]    mem_byteenable;
    logic          mem_chipselect, mem_write, mem_clken;
    logic [31:0]   mem_writedata;
    logic [31:0]   mem_readdata = '0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    host_memory_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
    );

    // Behavioural RAM, every word preset to 0xDEADBEEF, one-cycle read.
    logic [31:0] ram [0:2047];
    initial for (int i = 0; i < 2048; i++) ram[i] = 32'hDEADBEEF;
    always @(posedge clk) begin
        if (mem_chipselect && mem_clken) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end else begin
                mem_readdata <= ram[mem_address];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          own = -1;        // current owner, -1 = nobody
    int          run = 0;         // consecutive grants to own
    int          lst = 1;         // last master granted
    bit          pend = 1'b0;
    int          pend_who = 0;
    logic [31:0] pend_data = '0;
    logic [31:0] shadow [0:2047];
    initial for (int i = 0; i < 2048; i++) shadow[i] = 32'hDEADBEEF;

    always @(negedge clk) begin
        bit          rq [2];
        bit          wr [2];
        logic [10:0] ad [2];
        logic [3:0]  be [2];
        logic [31:0] wd [2];
        int          g;
        rq[0] = m0_read | m0_write;  rq[1] = m1_read | m1_write;
        wr[0] = m0_write;            wr[1] = m1_write;
        ad[0] = m0_address;          ad[1] = m1_address;
        be[0] = m0_byteenable;       be[1] = m1_byteenable;
        wd[0] = m0_writedata;        wd[1] = m1_writedata;

        g = -1;
        if (!reset) begin
            if (own < 0) begin
                if (rq[0] && rq[1]) g = 1 - lst;
                else if (rq[0])     g = 0;
                else if (rq[1])     g = 1;
            end else if (rq[own] && (run < MAX_BURST || !rq[1-own])) begin
                g = own;
            end else if (rq[1-own]) begin
                g = 1 - own;
            end
        end

        chk("m0_waitrequest", 32'(m0_waitrequest), 32'(rq[0] && g != 0));
        chk("m1_waitrequest", 32'(m1_waitrequest), 32'(rq[1] && g != 1));
        chk("mem_chipselect", 32'(mem_chipselect), 32'(g >= 0));
        chk("mem_write",      32'(mem_write),      32'(g >= 0 && wr[g]));
        chk("mem_address",    32'(mem_address),    (g >= 0) ? 32'(ad[g]) : 32'd0);
        chk("mem_byteenable", 32'(mem_byteenable), (g >= 0) ? 32'(be[g]) : 32'd0);
        chk("mem_writedata",  mem_writedata,       (g >= 0) ? wd[g] : 32'd0);
        chk("mem_clken",      32'(mem_clken),      32'd1);
        chk("m0_readdatavalid", 32'(m0_readdatavalid), 32'(!reset && pend && pend_who == 0));
        chk("m1_readdatavalid", 32'(m1_readdatavalid), 32'(!reset && pend && pend_who == 1));
        if (!reset && pend && pend_who == 0) chk("m0_readdata", m0_readdata, pend_data);
        if (!reset && pend && pend_who == 1) chk("m1_readdata", m1_readdata, pend_data);

        // advance model to the state after the coming clock edge
        if (reset) begin
            own = -1; run = 0; lst = 1; pend = 1'b0;
        end else begin
            pend = 1'b0;
            if (g < 0) begin
                own = -1; run = 0;
            end else begin
                run = (g == own) ? ((run < 15) ? run + 1 : 15) : 1;
                own = g; lst = g;
                if (wr[g]) begin
                    for (int b = 0; b < 4; b++)
                        if (be[g][b]) shadow[ad[g]][8*b +: 8] = wd[g][8*b +: 8];
                end else begin
                    pend = 1'b1; pend_who = g; pend_data = shadow[ad[g]];
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle_all();
        m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    endtask

    task automatic gen(output logic rd, output logic wr, output logic [10:0] a,
                       output logic [3:0] be, output logic [31:0] wd);
        int k;
        k  = $urandom_range(0, 9);
        rd = ((k >= 3) && (k <= 6)) || (k == 9);
        wr = (k >= 7);
        a  = ($urandom_range(0, 7) == 0) ? 11'h7FF : 11'($urandom_range(0, 15));
        be = 4'($urandom_range(0, 15));
        wd = $urandom;
    endtask

    initial begin
        logic [11:0] pat;
        bit          a0, a1;

        // 1: single read after reset
        step(); step();
        reset = 0;
        m0_read = 1; m0_address = 11'h005;
        @(negedge clk); chk("t1 m0 granted", 32'(m0_waitrequest), 32'd0);
        step(); idle_all();
        @(negedge clk);
        chk("t1 rdvalid", 32'(m0_readdatavalid), 32'd1);
        chk("t1 rddata", m0_readdata, 32'hDEADBEEF);
        step();

        // 2: partial write to the top word, read back
        m0_write = 1; m0_address = 11'h7FF; m0_writedata = 32'h12345678; m0_byteenable = 4'b0011;
        @(negedge clk); chk("t2 write accepted", 32'(m0_waitrequest), 32'd0);
        step(); m0_write = 0; m0_read = 1;
        step(); idle_all();
        @(negedge clk);
        chk("t2 rdvalid", 32'(m0_readdatavalid), 32'd1);
        chk("t2 rddata", m0_readdata, 32'hDEAD5678);
        step();

        // 3: both stream reads from the first post-reset cycle
        reset = 1; step(); reset = 0;
        m0_read = 1; m0_address = 11'h010; m1_read = 1; m1_address = 11'h020;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            pat[i] = ~m1_waitrequest;
            chk("t3 one grant", 32'(m0_waitrequest ^ m1_waitrequest), 32'd1);
            step();
        end
        chk("t3 burst pattern", 32'(pat), 32'(12'b0000_1111_0000));
        idle_all(); step();

        // 4: M1 alone never stalls; M0 joining late wins at once
        reset = 1; step(); reset = 0;
        m1_read = 1; m1_address = 11'h003;
        for (int i = 0; i < 14; i++) begin
            if (i == 10) begin m0_read = 1; m0_address = 11'h004; end
            @(negedge clk);
            if (i < 10)  chk("t4 m1 no stall", 32'(m1_waitrequest), 32'd0);
            if (i == 10) chk("t4 m0 granted", 32'(m0_waitrequest), 32'd0);
            step();
        end
        idle_all(); step();

        // 5: reset interactions
        reset = 1; m1_read = 1; m1_address = 11'h009;
        @(negedge clk);
        chk("t5 held in reset", 32'(m1_waitrequest), 32'd1);
        chk("t5 no chipselect", 32'(mem_chipselect), 32'd0);
        step(); reset = 0;
        @(negedge clk); chk("t5 m1 accepted", 32'(m1_waitrequest), 32'd0);
        step(); m1_read = 0; reset = 1;
        @(negedge clk); chk("t5 no rv in reset", 32'(m1_readdatavalid), 32'd0);
        step(); reset = 0; m0_read = 1; m1_read = 1;
        @(negedge clk);
        chk("t5 no rv after", 32'(m1_readdatavalid), 32'd0);
        chk("t5 m0 wins tie", 32'(m0_waitrequest), 32'd0);
        chk("t5 m1 waits", 32'(m1_waitrequest), 32'd1);
        step(); idle_all(); step();

        // 6: random traffic, masters hold requests while stalled
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            a0 = !(m0_read | m0_write) || !m0_waitrequest;
            a1 = !(m1_read | m1_write) || !m1_waitrequest;
            step();
            reset = ($urandom_range(0, 199) == 0);
            if (a0) gen(m0_read, m0_write, m0_address, m0_byteenable, m0_writedata);
            if (a1) gen(m1_read, m1_write, m1_address, m1_byteenable, m1_writedata);
        end
        reset = 0; idle_all();
        step(); step();
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
